// File: rtl/rf_write_arbiter_if.sv
// Write-port bundle between two requesters, the init control and the register file.
interface rf_write_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              in_a_req;
    logic [ADDR_W-1:0] in_a_add;
    logic [DATA_W-1:0] in_a_val;
    logic              out_a_gnt;
    logic              in_b_req;
    logic [ADDR_W-1:0] in_b_add;
    logic [DATA_W-1:0] in_b_val;
    logic              out_b_gnt;
    logic              in_init_start;
    logic [ADDR_W-1:0] out_write_reg_add;
    logic [DATA_W-1:0] out_write_reg_val;
    logic              out_write_en;
    logic              out_init_busy;

    modport master (
        output in_a_req, in_a_add, in_a_val, in_b_req, in_b_add, in_b_val, in_init_start,
        input  out_a_gnt, out_b_gnt, out_write_reg_add, out_write_reg_val, out_write_en,
               out_init_busy
    );

    modport slave (
        input  in_a_req, in_a_add, in_a_val, in_b_req, in_b_add, in_b_val, in_init_start,
        output out_a_gnt, out_b_gnt, out_write_reg_add, out_write_reg_val, out_write_en,
               out_init_busy
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester round-robin register-file write arbiter. Defining RF_INIT_EN adds
// an init sweep that writes INIT_VAL to every entry after reset or on in_init_start.
module rf_write_arbiter #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic               in_clk,
    input logic               in_rst,
    rf_write_arbiter_if.slave bus
);
    logic              r_fav_b;
    logic              r_en;
    logic [ADDR_W-1:0] r_add;
    logic [DATA_W-1:0] r_val;
    logic              w_arb;
    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_wr;
    logic [ADDR_W-1:0] w_add;
    logic [DATA_W-1:0] w_val;

`ifdef RF_INIT_EN
    typedef enum logic {ST_INIT, ST_ARB} state_t;

    // One bit wider than the address so the sweep end is seen without wrapping.
    localparam logic [ADDR_W:0] SWEEP_END = {1'b1, {ADDR_W{1'b0}}};

    state_t          r_state;
    state_t          w_state_nxt;
    logic [ADDR_W:0] r_cnt;
    logic [ADDR_W:0] w_cnt_nxt;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == SWEEP_END) begin
                    w_state_nxt = ST_ARB;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_ARB: begin
                if (bus.in_init_start) begin
                    w_state_nxt = ST_INIT;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = ST_ARB;
        endcase
    end

    assign w_arb             = (r_state == ST_ARB);
    assign bus.out_init_busy = (r_state == ST_INIT);
`else
    logic w_unused;

    assign w_unused          = bus.in_init_start;
    assign w_arb             = 1'b1;
    assign bus.out_init_busy = 1'b0;
`endif

    // Contention goes to whoever was not granted last; r_fav_b=0 favours A.
    assign w_a_gnt = in_rst & w_arb & bus.in_a_req & (~bus.in_b_req | ~r_fav_b);
    assign w_b_gnt = in_rst & w_arb & bus.in_b_req & (~bus.in_a_req | r_fav_b);

    always_comb begin
        w_wr  = 1'b0;
        w_add = bus.in_a_add;
        w_val = bus.in_a_val;
        if (w_a_gnt) begin
            w_wr = 1'b1;
        end else if (w_b_gnt) begin
            w_wr  = 1'b1;
            w_add = bus.in_b_add;
            w_val = bus.in_b_val;
        end
`ifdef RF_INIT_EN
        if (r_state == ST_INIT && r_cnt != SWEEP_END) begin
            w_wr  = 1'b1;
            w_add = r_cnt[ADDR_W-1:0];
            w_val = INIT_VAL;
        end
`endif
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_en    <= 1'b0;
            r_add   <= '0;
            r_val   <= '0;
            r_fav_b <= 1'b0;
        end else begin
            r_en <= w_wr;
            if (w_wr) begin
                r_add <= w_add;
                r_val <= w_val;
            end
            if (w_a_gnt)      r_fav_b <= 1'b1;
            else if (w_b_gnt) r_fav_b <= 1'b0;
        end
    end

    assign bus.out_a_gnt         = w_a_gnt;
    assign bus.out_b_gnt         = w_b_gnt;
    assign bus.out_write_en      = r_en;
    assign bus.out_write_reg_add = r_add;
    assign bus.out_write_reg_val = r_val;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a cycle-level behavioural model;
// the sweep scenarios are exercised when built with RF_INIT_EN.
module tb_rf_write_arbiter;
    localparam int                ADDR_W   = 8;
    localparam int                DATA_W   = 16;
    localparam int                NENT     = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] INIT_VAL = '0;
`ifdef RF_INIT_EN
    localparam bit HAS_INIT = 1'b1;
`else
    localparam bit HAS_INIT = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    rf_write_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_VAL(INIT_VAL)) dut (
        .in_clk (clk),
        .in_rst (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: sweep flag + next sweep address, RR preference, expected registered write.
    bit          m_sweep;
    int          m_next;
    bit          m_fav_a;
    bit          m_en;
    logic [31:0] m_add;
    logic [31:0] m_val;

    bit                d_a_req, d_b_req, d_init;
    logic [ADDR_W-1:0] d_a_add, d_b_add;
    logic [DATA_W-1:0] d_a_val, d_b_val;
    bit                a_pend, b_pend;

    function automatic void model_reset();
        m_sweep = HAS_INIT;
        m_next  = 0;
        m_fav_a = 1'b1;
        m_en    = 1'b0;
        m_add   = '0;
        m_val   = '0;
        a_pend  = 1'b0;
        b_pend  = 1'b0;
    endfunction

    // Starts and ends on a falling edge; one rising edge in between.
    task automatic step();
        bit ga, gb;
        bus.in_a_req      = d_a_req;
        bus.in_a_add      = d_a_add;
        bus.in_a_val      = d_a_val;
        bus.in_b_req      = d_b_req;
        bus.in_b_add      = d_b_add;
        bus.in_b_val      = d_b_val;
        bus.in_init_start = d_init;
        #1;
        ga = !m_sweep && d_a_req && (!d_b_req || m_fav_a);
        gb = !m_sweep && d_b_req && (!d_a_req || !m_fav_a);
        chk("a_gnt", 32'(bus.out_a_gnt), 32'(ga));
        chk("b_gnt", 32'(bus.out_b_gnt), 32'(gb));
        chk("init_busy", 32'(bus.out_init_busy), 32'(m_sweep));
        if (m_sweep) begin
            if (m_next < NENT) begin
                m_en  = 1'b1;
                m_add = 32'(m_next);
                m_val = 32'(INIT_VAL);
                m_next++;
            end else begin
                m_en    = 1'b0;
                m_sweep = 1'b0;
            end
        end else begin
            m_en = ga || gb;
            if (ga) begin
                m_add   = 32'(d_a_add);
                m_val   = 32'(d_a_val);
                m_fav_a = 1'b0;
            end else if (gb) begin
                m_add   = 32'(d_b_add);
                m_val   = 32'(d_b_val);
                m_fav_a = 1'b1;
            end
            if (HAS_INIT && d_init) begin
                m_sweep = 1'b1;
                m_next  = 0;
            end
        end
        a_pend = d_a_req && !ga;
        b_pend = d_b_req && !gb;
        @(negedge clk);
        chk("write_en", 32'(bus.out_write_en), 32'(m_en));
        chk("write_add", 32'(bus.out_write_reg_add), m_add);
        chk("write_val", 32'(bus.out_write_reg_val), m_val);
    endtask

    // Asserted mid-cycle with requests high: outputs must clear without a clock edge.
    task automatic do_reset();
        rst_n        = 1'b0;
        bus.in_a_req = 1'b1;
        bus.in_b_req = 1'b1;
        #1;
        model_reset();
        chk("rst_write_en", 32'(bus.out_write_en), 32'd0);
        chk("rst_write_add", 32'(bus.out_write_reg_add), 32'd0);
        chk("rst_write_val", 32'(bus.out_write_reg_val), 32'd0);
        chk("rst_a_gnt", 32'(bus.out_a_gnt), 32'd0);
        chk("rst_b_gnt", 32'(bus.out_b_gnt), 32'd0);
        chk("rst_busy", 32'(bus.out_init_busy), 32'(HAS_INIT));
        @(negedge clk);
        rst_n   = 1'b1;
        d_a_req = 1'b0;
        d_b_req = 1'b0;
        d_init  = 1'b0;
    endtask

    task automatic rand_drive();
        if (!a_pend) begin
            d_a_req = ($urandom_range(0, 99) < 55);
            d_a_add = ADDR_W'($urandom);
            d_a_val = DATA_W'($urandom);
        end
        if (!b_pend) begin
            d_b_req = ($urandom_range(0, 99) < 55);
            d_b_add = ADDR_W'($urandom);
            d_b_val = DATA_W'($urandom);
        end
        d_init = ($urandom_range(0, 99) < 2);
    endtask

    task automatic finish_sweep();
        for (int i = 0; i < NENT + 4 && m_sweep; i++) step();
    endtask

    initial begin
        d_a_req = 0; d_b_req = 0; d_init = 0;
        d_a_add = '0; d_b_add = '0; d_a_val = '0; d_b_val = '0;
        bus.in_a_add = '0; bus.in_a_val = '0; bus.in_b_add = '0; bus.in_b_val = '0;
        bus.in_init_start = 1'b0;
        @(negedge clk);
        do_reset();

`ifdef RF_INIT_EN
        // Sweep from reset; A starts requesting at sweep address 0x10 and must wait.
        repeat (16) step();
        d_a_req = 1'b1; d_a_add = 8'h33; d_a_val = 16'h5A5A;
        finish_sweep();
        step();
        d_a_req = 1'b0;
        // Reset while address 0x80 is being written, then check restart from 0.
        do_reset();
        repeat (16'h81) step();
        do_reset();
        repeat (3) step();
        finish_sweep();
`endif

        // Single requester B, then single requester A.
        d_b_req = 1'b1; d_b_add = 8'hFF; d_b_val = 16'hBEEF;
        step();
        d_b_req = 1'b0;
        d_a_req = 1'b1; d_a_add = 8'h05; d_a_val = 16'h1234;
        step();
        d_a_req = 1'b0;
        step();

        // Both requesting continuously right after reset: A, B, A, B.
        do_reset();
        finish_sweep();
        for (int i = 0; i < 4; i++) begin
            if (!a_pend) begin d_a_add = ADDR_W'(i); d_a_val = DATA_W'(16'hA000 + i); end
            if (!b_pend) begin d_b_add = ADDR_W'(8'h80 + i); d_b_val = DATA_W'(16'hB000 + i); end
            d_a_req = 1'b1;
            d_b_req = 1'b1;
            step();
        end
        d_a_req = 1'b0; d_b_req = 1'b0;
        step();

        for (int i = 0; i < 1500; i++) begin
            rand_drive();
            step();
            if ($urandom_range(0, 299) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
